// File: rtl/controlador_tablero_pkg.sv
// Shared types for the two-board shooting game: board size, cell codes,
// game FSM states and packed-board index helpers.
package tablero_pkg;

    localparam int unsigned N = 5;

    typedef enum logic [1:0] {
        WATER = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        S_PLAYER = 2'd0,
        S_PC     = 2'd1,
        S_OVER   = 2'd2
    } state_t;

    function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                        input int unsigned n = N);
        return r * n + c;
    endfunction

    function automatic logic shootable(input cell_t cur);
        return (cur == WATER) || (cur == SHIP);
    endfunction

    function automatic cell_t shot(input cell_t cur);
        return (cur == SHIP) ? HIT : MISS;
    endfunction

endpackage

// File: rtl/controlador_tablero_cursor_ctrl.sv
// Player cursor registers with up > down > left > right move priority.
// CURSOR_WRAP_EN selects wrap-around moves; saturating moves otherwise.
module cursor_ctrl #(
    parameter int unsigned N = tablero_pkg::N
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    output logic [2:0] o_row,
    output logic [2:0] o_col
);

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [2:0] LAST = 3'(N - 1);

    logic [2:0] r_row;
    logic [2:0] r_col;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (i_up)
                r_row <= (r_row == '0) ? (WRAP ? LAST : '0) : r_row - 3'd1;
            else if (i_down)
                r_row <= (r_row == LAST) ? (WRAP ? '0 : LAST) : r_row + 3'd1;
            else if (i_left)
                r_col <= (r_col == '0) ? (WRAP ? LAST : '0) : r_col - 3'd1;
            else if (i_right)
                r_col <= (r_col == LAST) ? (WRAP ? '0 : LAST) : r_col + 3'd1;
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

// File: rtl/controlador_tablero.sv
// Game-state engine: player/PC boards, turn FSM, PC shot handshake and game end.
// Cursor wrap behaviour is selected in cursor_ctrl by CURSOR_WRAP_EN.
module controlador_tablero #(
    parameter int unsigned        N            = tablero_pkg::N,
    parameter logic [N*N-1:0]     PLAYER_SHIPS = 25'h0000003,
    parameter logic [N*N-1:0]     PC_SHIPS     = 25'h0000021
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_fire,
    input  logic               pc_shot_valid,
    input  logic [2:0]         pc_row,
    input  logic [2:0]         pc_col,
    output logic               pc_shot_ready,
    output logic               pc_shot_err,
    output logic [2*N*N-1:0]   board_player,
    output logic [2*N*N-1:0]   board_pc,
    output logic [2:0]         cursor_row,
    output logic [2:0]         cursor_col,
    output logic               turn,
    output logic               game_over,
    output logic               winner
);

    import tablero_pkg::*;

    localparam int unsigned CELLS = N * N;
    localparam int unsigned CW    = $clog2(CELLS + 1);
    localparam logic [3:0]  N_LIM = 4'(N);

    function automatic logic [2*CELLS-1:0] load_board(input logic [CELLS-1:0] mask);
        logic [2*CELLS-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < CELLS; i++)
            b[2*i +: 2] = mask[i] ? SHIP : WATER;
        return b;
    endfunction

    localparam logic [2*CELLS-1:0] INIT_PLAYER = load_board(PLAYER_SHIPS);
    localparam logic [2*CELLS-1:0] INIT_PC     = load_board(PC_SHIPS);
    localparam logic [CW-1:0]      POP_PLAYER  = CW'($countones(PLAYER_SHIPS));
    localparam logic [CW-1:0]      POP_PC      = CW'($countones(PC_SHIPS));

    state_t             r_state;
    logic [2*CELLS-1:0] r_board_player;
    logic [2*CELLS-1:0] r_board_pc;
    logic [2*CELLS-1:0] r_board_pc_vis;
    logic [CW-1:0]      r_left_player;
    logic [CW-1:0]      r_left_pc;
    logic               r_turn;
    logic               r_game_over;
    logic               r_winner;
    logic               r_ready;
    logic               r_err;

    logic               w_cursor_en;
    logic [2:0]         w_cur_row;
    logic [2:0]         w_cur_col;
    int unsigned        w_pl_idx;
    int unsigned        w_pc_idx;
    cell_t              w_pl_cell;
    cell_t              w_pc_cell;
    logic               w_pc_in_range;

    // A zero ship count is only possible straight out of reset; hold the cursor then.
    assign w_cursor_en = (r_state == S_PLAYER) && (r_left_pc != '0) && (r_left_player != '0);

    cursor_ctrl #(.N(N)) u_cursor (
        .clock   (clock),
        .reset   (reset),
        .i_en    (w_cursor_en),
        .i_up    (btn_up),
        .i_down  (btn_down),
        .i_left  (btn_left),
        .i_right (btn_right),
        .o_row   (w_cur_row),
        .o_col   (w_cur_col)
    );

    always_comb begin
        w_pl_idx      = idx(32'(w_cur_row), 32'(w_cur_col), N);
        w_pl_cell     = cell_t'(r_board_pc[2*w_pl_idx +: 2]);
        w_pc_in_range = ({1'b0, pc_row} < N_LIM) && ({1'b0, pc_col} < N_LIM);
        w_pc_idx      = w_pc_in_range ? idx(32'(pc_row), 32'(pc_col), N) : 0;
        w_pc_cell     = cell_t'(r_board_player[2*w_pc_idx +: 2]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_PLAYER;
            r_board_player <= INIT_PLAYER;
            r_board_pc     <= INIT_PC;
            r_board_pc_vis <= '0;
            r_left_player  <= POP_PLAYER;
            r_left_pc      <= POP_PC;
            r_turn         <= 1'b0;
            r_game_over    <= 1'b0;
            r_winner       <= 1'b0;
            r_ready        <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_PLAYER: begin
                    if ((r_left_pc == '0) || (r_left_player == '0)) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                        r_winner    <= (r_left_pc == '0) ? 1'b0 : 1'b1;
                    end else if (btn_fire && shootable(w_pl_cell)) begin
                        r_board_pc[2*w_pl_idx +: 2]     <= shot(w_pl_cell);
                        r_board_pc_vis[2*w_pl_idx +: 2] <= shot(w_pl_cell);
                        if ((w_pl_cell == SHIP) && (r_left_pc == CW'(1))) begin
                            r_left_pc   <= '0;
                            r_state     <= S_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= 1'b0;
                        end else begin
                            if (w_pl_cell == SHIP)
                                r_left_pc <= r_left_pc - CW'(1);
                            r_state <= S_PC;
                            r_turn  <= 1'b1;
                        end
                    end
                end
                S_PC: begin
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (pc_shot_valid) begin
                        if (!w_pc_in_range || !shootable(w_pc_cell)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_board_player[2*w_pc_idx +: 2] <= shot(w_pc_cell);
                            r_ready <= 1'b0;
                            if ((w_pc_cell == SHIP) && (r_left_player == CW'(1))) begin
                                r_left_player <= '0;
                                r_state       <= S_OVER;
                                r_game_over   <= 1'b1;
                                r_winner      <= 1'b1;
                            end else begin
                                if (w_pc_cell == SHIP)
                                    r_left_player <= r_left_player - CW'(1);
                                r_state <= S_PLAYER;
                                r_turn  <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign board_player  = r_board_player;
    assign board_pc      = r_board_pc_vis;
    assign cursor_row    = w_cur_row;
    assign cursor_col    = w_cur_col;
    assign turn          = r_turn;
    assign game_over     = r_game_over;
    assign winner        = r_winner;
    assign pc_shot_ready = r_ready;
    assign pc_shot_err   = r_err;

endmodule

// File: tb/tb_controlador_tablero.sv
// Directed bench for controlador_tablero with a scoreboard of expected output snapshots.
module tb_controlador_tablero;

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        btn_up, btn_down, btn_left, btn_right, btn_fire;
    logic        pc_shot_valid;
    logic [2:0]  pc_row, pc_col;

    logic        pc_shot_ready, pc_shot_err;
    logic [49:0] board_player, board_pc;
    logic [2:0]  cursor_row, cursor_col;
    logic        turn, game_over, winner;

    logic        z_ready, z_err;
    logic [49:0] z_bp, z_bpc;
    logic [2:0]  z_row, z_col;
    logic        z_turn, z_go, z_win;

    controlador_tablero #(.N(5), .PLAYER_SHIPS(25'h0000003), .PC_SHIPS(25'h0000021)) dut (
        .clock(clock), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_fire(btn_fire), .pc_shot_valid(pc_shot_valid), .pc_row(pc_row), .pc_col(pc_col),
        .pc_shot_ready(pc_shot_ready), .pc_shot_err(pc_shot_err),
        .board_player(board_player), .board_pc(board_pc),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .turn(turn), .game_over(game_over), .winner(winner)
    );

    // Player starts with no ships: the PC must be declared winner right after reset.
    controlador_tablero #(.N(5), .PLAYER_SHIPS(25'h0000000), .PC_SHIPS(25'h0000021)) dut_zero (
        .clock(clock), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_fire(btn_fire), .pc_shot_valid(pc_shot_valid), .pc_row(pc_row), .pc_col(pc_col),
        .pc_shot_ready(z_ready), .pc_shot_err(z_err),
        .board_player(z_bp), .board_pc(z_bpc),
        .cursor_row(z_row), .cursor_col(z_col),
        .turn(z_turn), .game_over(z_go), .winner(z_win)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [49:0] bp, bpc;
        logic [2:0]  r, c;
        logic        turn, go, win, rdy, err, zgo, zwin;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [49:0] e_bp, e_bpc;
    logic [2:0]  e_r, e_c;
    logic        e_turn, e_go, e_win, e_rdy, e_err, e_zgo, e_zwin;

    function automatic logic [49:0] setc(input logic [49:0] b, input int unsigned i,
                                         input logic [1:0] v);
        logic [49:0] t;
        t = b;
        t[2*i +: 2] = v;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_exp();
        e_bp = 50'h5; e_bpc = '0; e_r = '0; e_c = '0;
        e_turn = 0; e_go = 0; e_win = 0; e_rdy = 0; e_err = 0;
        e_zgo = 0; e_zwin = 0;
    endtask

    task automatic step(input string tag);
        exp_t e;
        e.tag = tag; e.bp = e_bp; e.bpc = e_bpc; e.r = e_r; e.c = e_c;
        e.turn = e_turn; e.go = e_go; e.win = e_win; e.rdy = e_rdy; e.err = e_err;
        e.zgo = e_zgo; e.zwin = e_zwin;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".board_player"}, 64'(board_player), 64'(e.bp));
        chk({e.tag, ".board_pc"},     64'(board_pc),     64'(e.bpc));
        chk({e.tag, ".cursor_row"},   64'(cursor_row),   64'(e.r));
        chk({e.tag, ".cursor_col"},   64'(cursor_col),   64'(e.c));
        chk({e.tag, ".turn"},         64'(turn),         64'(e.turn));
        chk({e.tag, ".game_over"},    64'(game_over),    64'(e.go));
        chk({e.tag, ".winner"},       64'(winner),       64'(e.win));
        chk({e.tag, ".ready"},        64'(pc_shot_ready), 64'(e.rdy));
        chk({e.tag, ".err"},          64'(pc_shot_err),  64'(e.err));
        chk({e.tag, ".zero.game_over"}, 64'(z_go),       64'(e.zgo));
        chk({e.tag, ".zero.winner"},  64'(z_win),        64'(e.zwin));
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
        pc_shot_valid = 0;
    endtask

    // Drive move pulses and advance the expected cursor (player turn only).
    task automatic press(input logic u, input logic d, input logic l, input logic r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        if (u)      e_r = (e_r == 3'd0) ? (WRAP ? 3'd4 : 3'd0) : e_r - 3'd1;
        else if (d) e_r = (e_r == 3'd4) ? (WRAP ? 3'd0 : 3'd4) : e_r + 3'd1;
        else if (l) e_c = (e_c == 3'd0) ? (WRAP ? 3'd4 : 3'd0) : e_c - 3'd1;
        else if (r) e_c = (e_c == 3'd4) ? (WRAP ? 3'd0 : 3'd4) : e_c + 3'd1;
    endtask

    task automatic pc_shot(input logic [2:0] r, input logic [2:0] c);
        pc_shot_valid = 1; pc_row = r; pc_col = c;
    endtask

    initial begin
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
        pc_shot_valid = 0; pc_row = '0; pc_col = '0;
        reset = 1;
        reset_exp();
        step("reset");

        reset = 0; e_zgo = 1; e_zwin = 1;
        step("idle");

        btn_fire = 1; e_bpc = setc(e_bpc, 0, 2'd2); e_turn = 1;
        step("fire00");
        btn_fire = 1; btn_right = 1; e_rdy = 1;
        step("pc_turn_ignores_buttons");
        step("pc_wait");

        pc_shot(3'd0, 3'd1); e_bp = setc(e_bp, 1, 2'd2); e_turn = 0; e_rdy = 0;
        step("pc_hit01");

        for (int i = 0; i < 6; i++) begin
            press(0, 0, 0, 1);
            step("right");
        end
        press(1, 0, 0, 1);
        step("up_right");

        btn_fire = 1; e_bpc = setc(e_bpc, 32'(e_r) * 5 + 32'(e_c), 2'd3); e_turn = 1;
        step("fire_miss");
        e_rdy = 1;
        step("ready_up");

        pc_shot(3'd7, 3'd0); e_err = 1;
        step("pc_err_range");
        e_err = 0;
        step("err_clear1");
        pc_shot(3'd0, 3'd1); e_err = 1;
        step("pc_err_repeat");
        e_err = 0;
        step("err_clear2");

        pc_shot(3'd2, 3'd2); e_bp = setc(e_bp, 12, 2'd3); e_turn = 0; e_rdy = 0;
        step("pc_miss22");

        press(0, 1, 1, 1);
        step("prio_down");
        for (int k = 0; k < 8 && e_r != 3'd1; k++) begin
            press(0, 1, 0, 0);
            step("nav_row");
        end
        for (int k = 0; k < 8 && e_c != 3'd0; k++) begin
            press(0, 0, 1, 0);
            step("nav_col");
        end

        btn_fire = 1; press(0, 0, 0, 1);
        e_bpc = setc(e_bpc, 5, 2'd2); e_go = 1; e_win = 0;
        step("fire_move_win");

        btn_fire = 1; btn_up = 1; pc_shot(3'd0, 3'd0);
        step("over_hold1");
        btn_fire = 1; btn_left = 1; pc_shot(3'd2, 3'd3);
        step("over_hold2");

        reset = 1; reset_exp();
        step("reset2");
        reset = 0; e_zgo = 1; e_zwin = 1;
        btn_fire = 1; e_bpc = setc(e_bpc, 0, 2'd2); e_turn = 1;
        step("fire00_again");
        e_rdy = 1;
        step("ready_again");

        reset = 1; pc_shot(3'd0, 3'd0); reset_exp();
        step("reset_in_pc");
        reset = 0; e_zgo = 1; e_zwin = 1;
        step("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_tablero.md
Name: controlador_tablero

Overview:
- Game-state engine for the 5x5 two-board shooting game.
- Sits directly upstream of the VGA controller. Holds the player and PC board matrices and feeds them, plus the cursor position, to the display path.
- Runs turn alternation, player cursor moves and fire, and the PC shot handshake. Detects game end.

Parameters:
- N, 5, board side length (rows = cols = N).
- PLAYER_SHIPS, 25'h0000003, player ship mask; bit r*N+c set = ship at (r,c).
- PC_SHIPS, 25'h0000021, PC ship mask; same layout.

Ports:
- clock  in  1  system clock (same domain as the VGA controller input clock)
- reset  in  1  synchronous, active-high
- btn_up / btn_down / btn_left / btn_right  in  1 each  single-cycle move pulses (already debounced)
- btn_fire  in  1  single-cycle fire pulse
- pc_shot_valid  in  1  PC shot request
- pc_row, pc_col  in  3 each  PC target coordinates
- pc_shot_ready  out  1  high while a PC shot is accepted
- pc_shot_err  out  1  1-cycle pulse when a PC shot is rejected
- board_player  out  2*N*N  packed; cell (r,c) = bits [2*(r*N+c)+:2]
- board_pc  out  2*N*N  same packing; PC ships are masked
- cursor_row, cursor_col  out  3 each  player cursor
- turn  out  1  0 = player, 1 = PC
- game_over  out  1  game finished
- winner  out  1  0 = player, 1 = PC; valid when game_over = 1

Behaviour:
- Cell codes (2 bits):
  - 0 = water
  - 1 = ship
  - 2 = hit
  - 3 = miss
- board_pc output shows code 1 as 0. The internal state keeps 1.
- Reset (synchronous) values:
  - Player board loaded from PLAYER_SHIPS (1 where the mask bit is set, else 0); PC board loaded from PC_SHIPS.
  - ships_left_player = popcount(PLAYER_SHIPS); ships_left_pc = popcount(PC_SHIPS).
  - cursor = (0,0); turn = 0; game_over = 0; winner = 0; pc_shot_ready = 0; pc_shot_err = 0.
  - FSM = S_PLAYER.
- State S_PLAYER:
  - Move pulses update the cursor on the next edge.
  - Up/left at 0 and down/right at N-1 saturate.
  - Multiple move pulses in the same cycle: priority is up > down > left > right; only one is applied.
  - Fire with the target cell at code 0 or 1: the target becomes 3 (if 0) or 2 (if 1) on the next edge, then go to S_PC.
  - A hit also decrements ships_left_pc.
  - Fire on a cell at code 2 or 3 is ignored; stay in S_PLAYER.
  - Move and fire in the same cycle: fire uses the pre-move cursor, and the move is also applied.
- State S_PC:
  - turn = 1; pc_shot_ready = 1 (registered, asserted the cycle after entry).
  - Handshake: the shot is taken on the cycle where pc_shot_valid & pc_shot_ready.
  - Coordinates >= N, or a player cell at code 2 or 3: pc_shot_err pulses for 1 cycle, no board change, stay in S_PC.
  - Otherwise the player cell becomes 3 or 2 the same way as a player shot, and a hit decrements ships_left_player.
  - After an accepted shot, go to S_PLAYER; pc_shot_ready drops in that same edge.
  - Player buttons are ignored in S_PC.
- Game end:
  - After any board update where a ships_left counter reaches 0, go to S_OVER. There is no further turn change.
  - winner = 0 if ships_left_pc hit 0, else 1.
  - S_OVER holds all state and ignores all inputs until reset.
- Board update latency: 1 cycle from the accepted event to the board outputs.
- All outputs are registered.
- Reset mid-game restores the full reset state on the next edge, regardless of FSM state.
- A popcount of 0 in either mask at reset: enter S_OVER on the first cycle after reset.
  - The winner is the side whose opponent has 0 ships.
  - If both are 0, winner = 0.

Optional Feature:
- CURSOR_WRAP_EN
  - Defined: cursor moves wrap around (up at row 0 goes to N-1, right at N-1 goes to 0, etc.).
  - Undefined: cursor moves saturate as described above.
  - No other behaviour differs.

Decomposition:
- Package tablero_pkg holds:
  - localparam N = 5.
  - cell_t enum: WATER, SHIP, HIT, MISS.
  - state_t enum: S_PLAYER, S_PC, S_OVER.
  - Packed-index helper function idx(r,c).
- One sub-module, cursor_ctrl: the cursor registers, move priority and the CURSOR_WRAP_EN logic. It outputs cursor_row/col and takes an enable from the FSM.

Test Plan:
- Reset with the default masks -> board_player bits[3:0] = 4'b0101, board_pc all 0 (hidden), cursor (0,0), turn 0, ships_left 2/2.
- Fire at (0,0) -> next cycle board_pc cell 0 = 2, turn = 1, pc_shot_ready = 1 the following cycle. A second fire during S_PC produces no change.
- PC shot (0,1) valid for 1 cycle -> player cell 1 = 2, turn = 0. Then PC shot (7,0) or a repeat of (0,1) -> pc_shot_err 1-cycle pulse, board unchanged.
- Cursor: 6 btn_right pulses -> col = 4 without the macro, col = 1 with CURSOR_WRAP_EN. Simultaneous up+right at (0,0) -> no move (up saturates) without the macro, (4,0) with it.
- Player hits (0,0) and (1,0) across alternating turns (PC misses in between) -> game_over = 1, winner = 0. Further fire and PC valid -> no change.
- Assert reset in S_PC with pc_shot_valid high -> next cycle full reset values, pc_shot_ready = 0, no board update.
